// File: rtl/controlador_lavadora_pkg.sv
// Shared types and default configuration for the coin-operated washer/dryer controller.
package controlador_lavadora_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    RUN   = 2'd2,
    INSUF = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    SEC  = 2'd1,
    LAV  = 2'd2,
    PES  = 2'd3
  } prog_t;

  localparam int DEF_CREDIT_W = 4;
  localparam int DEF_PRICE_SEC = 3;
  localparam int DEF_PRICE_LAV = 4;
  localparam int DEF_PRICE_PES = 9;
  localparam int DEF_T_SEC = 30;
  localparam int DEF_T_LAV = 30;
  localparam int DEF_T_PES = 30;
  localparam int DEF_T_INS = 10;
  localparam int DEF_TIMER_W = 16;

endpackage

// File: rtl/controlador_lavadora_temporizador.sv
// Loadable down-counter shared by the program and insufficient-payment phases.
module temporizador #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               dec,
  output logic [TIMER_W-1:0] value,
  output logic               done
);

  logic [TIMER_W-1:0] count_r;

  // Load wins over decrement; the count parks at zero rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {TIMER_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {TIMER_W{1'b0}})) begin
      count_r <= count_r - TIMER_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign value = count_r;
  assign done  = (count_r == TIMER_W'(1));

endmodule

// File: rtl/controlador_lavadora_param.sv
// Coin credit, program selection and timed program/insufficient outputs.
// Optional best-fit selection with change output is enabled by defining CHANGE_EN.
module controlador_lavadora_param
  import controlador_lavadora_pkg::*;
#(
  parameter int CREDIT_W  = DEF_CREDIT_W,
  parameter int PRICE_SEC = DEF_PRICE_SEC,
  parameter int PRICE_LAV = DEF_PRICE_LAV,
  parameter int PRICE_PES = DEF_PRICE_PES,
  parameter int T_SEC     = DEF_T_SEC,
  parameter int T_LAV     = DEF_T_LAV,
  parameter int T_PES     = DEF_T_PES,
  parameter int T_INS     = DEF_T_INS,
  parameter int TIMER_W   = DEF_TIMER_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                INTRO_MONEDAS,
  input  logic                FINALIZAR_PAGO,
  output logic                SECADO,
  output logic                LAVADO,
  output logic                LAVADO_PESADO,
  output logic                INSUFICIENTE,
  output logic                BUSY,
  output logic [CREDIT_W-1:0] CREDITO,
  output logic [CREDIT_W-1:0] CAMBIO,
  output logic                CAMBIO_VALID
);

  localparam logic [CREDIT_W-1:0] P_SEC      = CREDIT_W'(PRICE_SEC);
  localparam logic [CREDIT_W-1:0] P_LAV      = CREDIT_W'(PRICE_LAV);
  localparam logic [CREDIT_W-1:0] P_PES      = CREDIT_W'(PRICE_PES);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = {CREDIT_W{1'b1}};
  localparam logic [TIMER_W-1:0]  D_SEC      = TIMER_W'(T_SEC);
  localparam logic [TIMER_W-1:0]  D_LAV      = TIMER_W'(T_LAV);
  localparam logic [TIMER_W-1:0]  D_PES      = TIMER_W'(T_PES);
  localparam logic [TIMER_W-1:0]  D_INS      = TIMER_W'(T_INS);

  state_t              state_r, state_nx_s;
  prog_t               prog_r, prog_nx_s, sel_s;
  logic [CREDIT_W-1:0] credit_r, credit_nx_s;
  logic                coin_prev_r, coin_edge_s;
  logic                sec_r, lav_r, pes_r, ins_r, ins_nx_s, busy_r;
  logic [TIMER_W-1:0]  dur_s, timer_val_s;
  logic                load_s, dec_s, timer_done_s, expire_s;

  assign coin_edge_s = INTRO_MONEDAS & ~coin_prev_r;
  assign load_s      = (state_r == EVAL);
  assign dec_s       = (state_r == RUN) || (state_r == INSUF);
  // A zero count is treated as expiry so a corrupted timer cannot stall the machine.
  assign expire_s    = timer_done_s || (timer_val_s == {TIMER_W{1'b0}});

  temporizador #(.TIMER_W(TIMER_W)) u_temporizador (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .load_val (dur_s),
    .dec      (dec_s),
    .value    (timer_val_s),
    .done     (timer_done_s)
  );

  // Program chosen from the current credit, and the duration it runs for.
  always_comb begin
    sel_s = NONE;
`ifdef CHANGE_EN
    if (credit_r >= P_PES) sel_s = PES;
    else if (credit_r >= P_LAV) sel_s = LAV;
    else if (credit_r >= P_SEC) sel_s = SEC;
    else sel_s = NONE;
`else
    if (credit_r == P_PES) sel_s = PES;
    else if (credit_r == P_LAV) sel_s = LAV;
    else if (credit_r == P_SEC) sel_s = SEC;
    else sel_s = NONE;
`endif
    case (sel_s)
      SEC:     dur_s = D_SEC;
      LAV:     dur_s = D_LAV;
      PES:     dur_s = D_PES;
      default: dur_s = D_INS;
    endcase
  end

  // Next-state, credit and output-request logic.
  always_comb begin
    state_nx_s  = state_r;
    credit_nx_s = credit_r;
    prog_nx_s   = prog_r;
    ins_nx_s    = ins_r;
    case (state_r)
      IDLE: begin
        if (coin_edge_s) begin
          credit_nx_s = (credit_r == CREDIT_MAX) ? credit_r : credit_r + CREDIT_W'(1);
        end else if (FINALIZAR_PAGO) begin
          state_nx_s = EVAL;
        end else begin
          state_nx_s = IDLE;
        end
      end
      EVAL: begin
        if (sel_s != NONE) begin
          state_nx_s = RUN;
          prog_nx_s  = sel_s;
        end else begin
          state_nx_s = INSUF;
          ins_nx_s   = 1'b1;
        end
      end
      RUN: begin
        if (expire_s) begin
          state_nx_s  = IDLE;
          prog_nx_s   = NONE;
          credit_nx_s = {CREDIT_W{1'b0}};
        end else begin
          state_nx_s = RUN;
        end
      end
      INSUF: begin
        if (expire_s) begin
          state_nx_s = IDLE;
          ins_nx_s   = 1'b0;
        end else begin
          state_nx_s = INSUF;
        end
      end
      default: begin
        state_nx_s = IDLE;
        prog_nx_s  = NONE;
        ins_nx_s   = 1'b0;
      end
    endcase
  end

  // State, credit and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      prog_r      <= NONE;
      credit_r    <= {CREDIT_W{1'b0}};
      coin_prev_r <= 1'b0;
      sec_r       <= 1'b0;
      lav_r       <= 1'b0;
      pes_r       <= 1'b0;
      ins_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      prog_r      <= prog_nx_s;
      credit_r    <= credit_nx_s;
      coin_prev_r <= INTRO_MONEDAS;
      sec_r       <= (prog_nx_s == SEC);
      lav_r       <= (prog_nx_s == LAV);
      pes_r       <= (prog_nx_s == PES);
      ins_r       <= ins_nx_s;
      busy_r      <= (state_nx_s != IDLE);
    end
  end

`ifdef CHANGE_EN
  logic [CREDIT_W-1:0] price_s, cambio_r;
  logic                cambio_valid_r;

  // Price of the program picked by the best-fit selector.
  always_comb begin
    case (sel_s)
      SEC:     price_s = P_SEC;
      LAV:     price_s = P_LAV;
      PES:     price_s = P_PES;
      default: price_s = {CREDIT_W{1'b0}};
    endcase
  end

  // Change is strobed once, on the edge that enters RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cambio_r       <= {CREDIT_W{1'b0}};
      cambio_valid_r <= 1'b0;
    end else if ((state_r == EVAL) && (sel_s != NONE)) begin
      cambio_r       <= credit_r - price_s;
      cambio_valid_r <= 1'b1;
    end else begin
      cambio_r       <= {CREDIT_W{1'b0}};
      cambio_valid_r <= 1'b0;
    end
  end

  assign CAMBIO       = cambio_r;
  assign CAMBIO_VALID = cambio_valid_r;
`else
  assign CAMBIO       = {CREDIT_W{1'b0}};
  assign CAMBIO_VALID = 1'b0;
`endif

  assign SECADO        = sec_r;
  assign LAVADO        = lav_r;
  assign LAVADO_PESADO = pes_r;
  assign INSUFICIENTE  = ins_r;
  assign BUSY          = busy_r;
  assign CREDITO       = credit_r;

endmodule

// File: doc/controlador_lavadora_param.md
# controlador_lavadora_param

Parametrised coin-operated washer/dryer controller. It accumulates coin credit, selects one of three programs (SECADO, LAVADO, LAVADO_PESADO) from the paid amount when payment is finalised, and holds the program output for a programmable number of clock cycles. An insufficient-payment indication is produced for a programmable duration. All timing is counter-based and synthesisable. It sits between the coin acceptor / pay button front end and the machine actuator drivers.

## Interface
- CREDIT_W, 4: credit counter width in bits.
- PRICE_SEC, 3: coins required for SECADO.
- PRICE_LAV, 4: coins required for LAVADO.
- PRICE_PES, 9: coins required for LAVADO_PESADO.
- T_SEC / T_LAV / T_PES, 30 / 30 / 30: program durations in clock cycles (≥1).
- T_INS, 10: INSUFICIENTE duration in cycles (≥1).
- TIMER_W, 16: duration counter width; every T_* must be < 2^TIMER_W.

- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low; asserts immediately, release synchronous to clk.
- INTRO_MONEDAS  input  1  coin strobe; each 0→1 transition is one coin.
- FINALIZAR_PAGO  input  1  end-of-payment request, level-sampled.
- SECADO, LAVADO, LAVADO_PESADO  output  1 each  program active, registered.
- INSUFICIENTE  output  1  payment rejected, registered.
- BUSY  output  1  high in every state except IDLE.
- CREDITO  output  CREDIT_W  current credit.
- CAMBIO  output  CREDIT_W  change amount, valid while CAMBIO_VALID (only with CHANGE_EN).
- CAMBIO_VALID  output  1  one-cycle change strobe (only with CHANGE_EN; tied 0 otherwise).

## Operation
- States: IDLE, EVAL, RUN, INSUF.
- Reset: state IDLE, credit 0, timer 0, coin edge register 0, all outputs 0.
- IDLE: coin edge → credit+1, saturating at 2^CREDIT_W−1. FINALIZAR_PAGO high with no coin edge that cycle → EVAL. A coin edge and FINALIZAR_PAGO in the same cycle: the coin is counted and FINALIZAR_PAGO is ignored that cycle.
- EVAL (one cycle): without CHANGE_EN, credit == PRICE_PES → LAVADO_PESADO; == PRICE_LAV → LAVADO; == PRICE_SEC → SECADO; otherwise → INSUF. With CHANGE_EN, the most expensive program with price ≤ credit is selected; if none, → INSUF.
- RUN: the selected output is high; the timer loads T_x on entry and decrements each cycle. At expiry, the output is cleared, credit is cleared to 0, and the state returns to IDLE.
- INSUF: INSUFICIENTE is high for T_INS cycles, then the state returns to IDLE. Credit is retained so the user can add coins.
- Coin edges in EVAL, RUN and INSUF are ignored and not counted. FINALIZAR_PAGO is ignored outside IDLE.
- Exactly one of SECADO, LAVADO, LAVADO_PESADO, INSUFICIENTE is high at any time, or none.
- Reset asserted mid-RUN or mid-INSUF: all outputs drop asynchronously and credit is lost.

## Timing
- Coin edge at cycle n → CREDITO updated at n+1.
- FINALIZAR_PAGO sampled at cycle n → EVAL at n+1 → program output high from n+2 for exactly T_x cycles. BUSY is high from n+1.
- INSUFICIENTE is high from n+2 for exactly T_INS cycles.
- The back-to-back minimum is one IDLE cycle between programs.
- A held-high INSTRO_MONEDAS counts as one coin only. A held FINALIZAR_PAGO re-triggers EVAL on the first IDLE cycle after completion.

## Configuration
- CHANGE_EN defined: best-fit selection as described above. On entry to RUN, CAMBIO = credit − price and CAMBIO_VALID pulses for one cycle.
- CHANGE_EN undefined: exact-match selection only. CAMBIO = 0 and CAMBIO_VALID = 0. Any non-matching credit → INSUF.

## Structure
- Package controlador_lavadora_pkg holds the state enum (IDLE/EVAL/RUN/INSUF), the program enum (NONE/SEC/LAV/PES), and the default price and duration constants.
- Sub-module temporizador: a loadable down-counter of TIMER_W bits with load, value and a done flag. It is instantiated once and shared by RUN and INSUF.
- The top level contains the coin edge detector, the credit counter, the selection logic and the FSM.

## Test plan
- Reset, 3 coin edges, then FINALIZAR_PAGO → SECADO high for exactly 30 cycles, CREDITO returns to 0, BUSY drops.
- 9 coins then FINALIZAR_PAGO → LAVADO_PESADO high for 30 cycles. With CHANGE_EN, 11 coins → LAVADO_PESADO with CAMBIO=2 strobed once.
- 5 coins without CHANGE_EN → INSUFICIENTE for 10 cycles and CREDITO stays 5. Add 4 more coins and finalise → LAVADO_PESADO.
- 5 coins with CHANGE_EN → LAVADO with CAMBIO=1. 2 coins → INSUFICIENTE.
- INTRO_MONEDAS held high for 20 cycles → CREDITO=1. Coin edge coincident with FINALIZAR_PAGO → coin counted, no EVAL. Coins during RUN → CREDITO unchanged.
- 16 coins with CREDIT_W=4 → CREDITO saturates at 15. Reset asserted mid-RUN → outputs 0 immediately, CREDITO=0, IDLE after release.
